// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: read response codes and the read-channel FSM state.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

endpackage : axil_pkg

// File: rtl/axil_reg_bank.sv
// Register bank: NUM_REGS x DATA_W flops with a local write port and a combinational read port.
module axil_reg_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] wr_idx_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    input  logic [$clog2(NUM_REGS)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]           rd_data_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is not visible to a captured read.
    assign rd_data_o = regs_q[rd_idx_i];

endmodule : axil_reg_bank

// File: rtl/axil_read_slave_regfile.sv
// AXI4-Lite read slave backed by a local register bank.
// Optional AXIL_RD_ADDR_CHECK_EN: misaligned or out-of-range reads return SLVERR with zero data.
module axil_read_slave_regfile
    import axil_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                        ACLK,
    input  logic                        rst,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    input  logic [ADDR_W-1:0]           ARADDR,
    input  logic [2:0]                  ARPROT,
    output logic                        RVALID,
    input  logic                        RREADY,
    output logic [DATA_W-1:0]           RDATA,
    output logic [1:0]                  RRESP,
    input  logic                        reg_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] reg_wr_idx,
    input  logic [DATA_W-1:0]           reg_wr_data
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // ARREADY and RVALID are pure flops; RDATA/RRESP hold while RVALID is high and RREADY low.

    rd_state_e         state_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0] rdata_d;
    logic [1:0]        rresp_d;
    logic              unused_bits;

    assign rd_idx = ARADDR[2 +: IDX_W];

    axil_reg_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk_i     (ACLK),
        .rst_i     (rst),
        .wr_en_i   (reg_wr_en),
        .wr_idx_i  (reg_wr_idx),
        .wr_data_i (reg_wr_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (bank_rdata)
    );

`ifdef AXIL_RD_ADDR_CHECK_EN
    logic addr_err;
    assign addr_err    = (ARADDR[1:0] != 2'b00) || (|ARADDR[ADDR_W-1:IDX_W+2]);
    assign rdata_d     = addr_err ? '0 : bank_rdata;
    assign rresp_d     = addr_err ? RESP_SLVERR : RESP_OKAY;
    assign unused_bits = ^ARPROT;
`else
    // Address wraps modulo the bank size; byte lanes and upper bits are dropped.
    assign rdata_d     = bank_rdata;
    assign rresp_d     = RESP_OKAY;
    assign unused_bits = ^{ARPROT, ARADDR[1:0], ARADDR[ADDR_W-1:IDX_W+2]};
`endif

    always_ff @(posedge ACLK) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (ARVALID && arready_q) begin
                        state_q   <= RD_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (RREADY) begin
                        state_q   <= RD_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RD_IDLE;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule : axil_read_slave_regfile
